// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and direction encoding for the counter and the downstream
// gray_to_binary converter. Helpers operate on a 32-bit word; callers zero-extend and truncate.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 4;
  localparam int GRAY_MAX_WIDTH     = 32;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  typedef enum logic {
    DN = 1'b0,
    UP = 1'b1
  } dir_e;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave the low bits unaffected.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_code_counter_binary_to_gray.sv
// Combinational binary-to-Gray encoder used on the counter's next-state path.
module binary_to_gray
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = WIDTH'(bin2gray(gray_word_t'(bin_i)));

endmodule

// File: rtl/gray_code_counter.sv
// Registered up/down Gray-code counter with aligned binary count and wrap pulse.
// Optional step checker (sticky err output) is enabled by defining GRAY_CNT_STEPCHK_EN.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             wrap
`ifdef GRAY_CNT_STEPCHK_EN
  ,
  output logic             err
`endif
);

  if (WIDTH < 2) begin : g_width_check
    $error("gray_code_counter: WIDTH must be at least 2");
  end

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             step;

  // Priority clr > load > en > hold; wrap only ever comes from a counting step.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    step   = 1'b0;
    if (clr) begin
      bin_d = '0;
    end else if (load) begin
      bin_d = load_val;
    end else if (en) begin
      step = 1'b1;
      if (dir_e'(up_dn) == UP) begin
        bin_d  = bin_q + 1'b1;
        wrap_d = (bin_q == CNT_MAX);
      end else begin
        bin_d  = bin_q - 1'b1;
        wrap_d = (bin_q == '0);
      end
    end
  end

  // Encode the next state so gray is a plain flop output and cannot glitch.
  binary_to_gray #(
    .WIDTH (WIDTH)
  ) u_binary_to_gray (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

`ifdef GRAY_CNT_STEPCHK_EN
  logic err_q, err_d;

  // Any counting step must move exactly one Gray bit; load and clr are not checked.
  always_comb begin
    err_d = err_q;
    if (clr) begin
      err_d = 1'b0;
    end else if (step && ($countones(gray_d ^ gray_q) != 1)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_gray_code_counter.sv
// Scoreboard bench for gray_code_counter: stimulus pushes hand-computed expectations,
// a monitor pops one per cycle and compares bin, gray, wrap and Gray/binary consistency.
module tb_gray_code_counter;
  import gray_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_dn, clr, load;
  logic [3:0] load_val;
  logic [3:0] gray, bin;
  logic       wrap;
`ifdef GRAY_CNT_STEPCHK_EN
  logic       err;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
    logic       w;
    logic       s;
  } exp_t;

  exp_t exp_q[$];

  // Hand-written Gray table indexed by binary value.
  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_code_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .gray     (gray),
    .bin      (bin),
    .wrap     (wrap)
`ifdef GRAY_CNT_STEPCHK_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic [3:0] lv, input logic [3:0] eb, input logic [3:0] eg,
                       input logic ew, input logic es);
    exp_t x;
    @(negedge clk);
    #1;
    en = e; up_dn = u; clr = c; load = l; load_val = lv;
    x.b = eb; x.g = eg; x.w = ew; x.s = es;
    exp_q.push_back(x);
  endtask

  // Monitor: one expectation per clock, sampled just after the active edge.
  initial begin : monitor
    exp_t       x;
    logic [3:0] prev_gray;
    logic [31:0] conv;
    prev_gray = 4'b0000;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("bin", 32'(bin), 32'(x.b));
        check("gray", 32'(gray), 32'(x.g));
        check("wrap", 32'(wrap), 32'(x.w));
        conv = gray2bin(gray_word_t'(gray));
        check("gray2bin_vs_bin", 32'(conv[3:0]), 32'(bin));
        if (x.s) check("single_bit_step", 32'($countones(gray ^ prev_gray)), 32'd1);
`ifdef GRAY_CNT_STEPCHK_EN
        check("err", 32'(err), 32'd0);
`endif
        prev_gray = gray;
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stimulus
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    #1;
    check("reset_bin", 32'(bin), 32'd0);
    check("reset_gray", 32'(gray), 32'd0);
    check("reset_wrap", 32'(wrap), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // idle after release
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0);

    // full up sweep, wrap on 15 -> 0
    for (int i = 0; i < 16; i++)
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'((i + 1) % 16), gtab[(i + 1) % 16], (i == 15), 1'b1);

    // down from 0 wraps to 15, then 14 without wrap
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd15, 4'b1000, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd14, 4'b1001, 1'b0, 1'b1);

    // load beats en; clr beats load and en
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'b0101, 4'd5, 4'b0111, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0101, 4'd0, 4'b0000, 1'b0, 1'b0);

    // loading the extremes never raises wrap
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 4'd15, 4'b1000, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'd0, 4'b0000, 1'b0, 1'b0);

    // direction changes between consecutive steps, across the boundary
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'b0001, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd15, 4'b1000, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 1'b1, 1'b1);

    // hold
    repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0);

    // full down sweep from 0
    for (int i = 0; i < 16; i++)
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'(15 - i), gtab[15 - i], (i == 0), 1'b1);

    // park at 6, then assert reset between edges
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 4'd6, 4'b0101, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    en = 1'b1; up_dn = 1'b1; load = 1'b0;
    drain();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_gray", 32'(gray), 32'd0);
    check("async_rst_bin", 32'(bin), 32'd0);
    check("async_rst_wrap", 32'(wrap), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // first step after release starts from 0
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'b0001, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'b0001, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_code_counter.md
Name: gray_code_counter

Overview:
- Registered up/down Gray-code counter.
- Sits directly upstream of the gray_to_binary converter and supplies its gray input, e.g. as a FIFO pointer or position code.
- Holds the binary count internally and registers the Gray encoding, so the gray output never glitches.
- Also exports the aligned binary count and a wrap pulse.

Parameters:
- WIDTH, 4, counter width in bits for bin, gray and load_val (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement. Sampled only when a step occurs.
- clr  input  1  synchronous clear to zero.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  binary value to load.
- gray  output  WIDTH  registered Gray code of the current count.
- bin  output  WIDTH  registered binary count, same cycle as gray.
- wrap  output  1  one-cycle pulse on modular wrap.

Behaviour:
- Reset (async assert, sync release): bin=0, gray=0, wrap=0. Reset asserted mid-count clears immediately and without waiting for a clock edge. The first step after release starts from 0.
- Priority per rising edge:
  - clr first: bin=0, gray=0, wrap=0.
  - else load: bin=load_val, gray=load_val^(load_val>>1), wrap=0.
  - else en: bin=bin±1 modulo 2^WIDTH, gray=next_bin^(next_bin>>1).
  - else: hold all values, wrap=0.
- Latency: one clock from en/clr/load sampled to updated bin/gray. bin and gray always encode the same value.
- Gray is computed from next-state binary and registered; it is not decoded combinationally from the output flop.
- On every en step, gray differs from its previous value in exactly one bit.
- Wrap:
  - up, bin=2^WIDTH-1, en=1 → bin=0, wrap=1 for that next cycle.
  - down, bin=0, en=1 → bin=2^WIDTH-1, wrap=1.
  - wrap is never set by load or clr, even if load_val is 0 or the max value.
- Direction change between consecutive steps is legal; the gray step is still a single bit.
- All arithmetic is unsigned WIDTH-bit with the carry/borrow discarded.

Optional Feature:
- Macro: GRAY_CNT_STEPCHK_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - err is sticky-set on the cycle after any en step whose registered gray change has a Hamming distance other than 1.
  - Cleared only by rst or clr.
  - Load cycles are excluded from the check.
- Undefined: no err port and no check logic; all other behaviour is identical.

Decomposition:
- Package gray_pkg holds:
  - constant GRAY_DEFAULT_WIDTH = 4;
  - functions bin2gray(b) = b^(b>>1) and gray2bin(g), the prefix XOR from MSB. The converter shares these.
  - typedef for the direction encoding (UP=1, DN=0).
- One natural sub-module: binary_to_gray (combinational, WIDTH-param), instantiated on the next-state path.
- Everything else stays flat.

Test Plan:
- rst=1 then release, en=0 for 3 cycles → bin=0000, gray=0000, wrap=0 held.
- en=1, up_dn=1 from 0 for 16 cycles:
  - gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,…,1000, then 0000.
  - wrap=1 only on the 1000→0000 cycle.
  - Each step changes exactly one bit.
- bin=0, en=1, up_dn=0 → bin=1111, gray=1000, wrap=1; next step → bin=1110, gray=1001, wrap=0.
- load=1, load_val=0101, en=1 → bin=0101, gray=0111, wrap=0.
- Same cycle clr=1, load=1, en=1 → bin=0000, gray=0000.
- Mid-count at bin=0110, assert rst between clock edges → gray=0000 before the next edge.
- Chain gray into gray_to_binary: converted output equals bin every cycle across a full up/down sweep.
